mem_bus_arbiter: RTL

- Shares the single-port data RAM and the memory-mapped I/O (switches, red LEDs) between two bus masters.
- Master 0 is the CPU; master 1 is the program loader/debug port.
- Sequences each access as a fixed three-state transaction, decodes the address to RAM or I/O, and acknowledges the owning master.
- Sits between the CPU's mem_cmd/mem_addr interface and the RAM/I/O at the board top level.

---
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data RAM and the switch/LED I/O page.
// Every access runs IDLE -> ACCESS -> RESP. Simultaneous requests are
// resolved round-robin. Address bit 8 selects RAM (0) or I/O (1).
module mem_bus_arbiter #(
  parameter int                    data_width = 16,
  parameter int                    addr_width = 9,
  parameter logic [addr_width-1:0] LED_ADDR   = 9'h100,
  parameter logic [addr_width-1:0] SW_ADDR    = 9'h140
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            m0_cmd,
  input  logic [addr_width-1:0] m0_addr,
  input  logic [data_width-1:0] m0_wdata,
  output logic [data_width-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic [1:0]            m1_cmd,
  input  logic [addr_width-1:0] m1_addr,
  input  logic [data_width-1:0] m1_wdata,
  output logic [data_width-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [addr_width-2:0] ram_addr,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  input  logic [7:0]            sw,
  output logic [7:0]            ledr,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b11;

  state_t                  state;
  state_t                  state_next;

  logic                    req0;
  logic                    req1;
  logic                    winner;
  logic [1:0]              sel_cmd;
  logic [addr_width-1:0]   sel_addr;
  logic [data_width-1:0]   sel_wdata;

  logic                    owner;       // 0 = m0, 1 = m1
  logic                    last_owner;
  logic [1:0]              cmd_q;
  logic [addr_width-1:0]   addr_q;
  logic [data_width-1:0]   wdata_q;
  logic [data_width-1:0]   io_rdata;
  logic [data_width-1:0]   rdata0_q;
  logic [data_width-1:0]   rdata1_q;

  logic                    is_write;
  logic                    is_read;
  logic                    is_ram;
  logic                    resp_fire;
  logic [data_width-1:0]   resp_data;

  // Both request encodings (01 write, 11 read) have bit 0 set.
  assign req0 = m0_cmd[0];
  assign req1 = m1_cmd[0];

  assign is_write = (cmd_q == CMD_WRITE);
  assign is_read  = (cmd_q == CMD_READ);
  assign is_ram   = ~addr_q[addr_width-1];

  // Reset masks the strobes in the cycle it is asserted so an abandoned
  // transaction never acks and never writes the RAM.
  assign resp_fire = (state == RESP) && !reset;
  assign resp_data = is_ram ? ram_dout : io_rdata;

  // Round-robin winner selection and mux of the winning master's request.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    winner = 1'b0;
    if (req0 && req1) winner = ~last_owner;
    else if (req1)    winner = 1'b1;
    sel_cmd   = winner ? m1_cmd   : m0_cmd;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
  end

  // Next-state logic for the fixed three-cycle transaction.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Latch the winning request and present RAM address/data on entry to ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else if (state == IDLE && (req0 || req1)) begin
      owner      <= winner;
      last_owner <= winner;
      cmd_q      <= sel_cmd;
      addr_q     <= sel_addr;
      wdata_q    <= sel_wdata;
      if (!sel_addr[addr_width-1]) begin
        ram_addr <= sel_addr[addr_width-2:0];
        ram_din  <= sel_wdata;
      end
    end
  end

  // I/O page: LED write and switch capture happen at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      ledr     <= '0;
      io_rdata <= '0;
    end else if (state == ACCESS) begin
      if (is_write && addr_q == LED_ADDR) ledr <= wdata_q[7:0];
      io_rdata <= (is_read && addr_q == SW_ADDR) ? {{(data_width-8){1'b0}}, sw} : '0;
    end
  end

  // Per-master read data holding registers, loaded as the read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == RESP && is_read) begin
      if (owner) rdata1_q <= resp_data;
      else       rdata0_q <= resp_data;
    end
  end

  // Outputs: during the ack cycle the owner sees the fresh read data directly,
  // since the synchronous RAM only delivers it in RESP.
  always_comb begin
    m0_ack    = resp_fire && !owner;
    m1_ack    = resp_fire &&  owner;
    m0_rdata  = (resp_fire && !owner && is_read) ? resp_data : rdata0_q;
    m1_rdata  = (resp_fire &&  owner && is_read) ? resp_data : rdata1_q;
    busy      = (state != IDLE);
    grant     = 2'b00;
    if (state != IDLE && !reset) grant = owner ? 2'b10 : 2'b01;
    ram_write = (state == ACCESS) && !reset && is_ram && is_write;
  end

endmodule
